fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream.sv | 119 +++++++++++
 tb/tb_fifo_rd_stream.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_rd_stream: drains a FIFO read port into a valid/ready stream through |
// | a 3-entry elastic buffer. Optional macro: FIFO_RD_STREAM_ERR_CHK_EN.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fifo_rd_stream #(
  parameter int WIDTH = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Fifo_Empty,
  output logic             o_Fifo_Rd_En,
  input  logic             i_Fifo_Rd_DV,
  input  logic [WIDTH-1:0] i_Fifo_Rd_Data,
  input  logic             i_Flush,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Data,
  input  logic             i_Ready,
  output logic [1:0]       o_Count,
  output logic             o_Err
);

  logic [WIDTH-1:0] mem [0:2];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [1:0]       count;
  logic             pend;
  logic             drop;
  logic [2:0]       occupancy;
  logic             cap;
  logic             pop;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Buffered words plus the one in flight must never exceed the buffer depth.
  assign occupancy    = {1'b0, count} + {2'b00, pend};
  assign o_Fifo_Rd_En = !i_Rst && !i_Flush && !i_Fifo_Empty && (occupancy < 3'd3);
  assign pop          = (count != 2'd0) && i_Ready && !i_Flush;

`ifdef FIFO_RD_STREAM_ERR_CHK_EN
  assign cap = i_Fifo_Rd_DV && pend && !drop;
`else
  assign cap = i_Fifo_Rd_DV && !drop && (count != 2'd3);
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
      pend   <= 1'b0;
      drop   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        mem[i] <= '0;
      end
    end else begin
      pend <= o_Fifo_Rd_En;
      if (i_Flush) begin
        wr_ptr <= 2'd0;
        rd_ptr <= 2'd0;
        count  <= 2'd0;
        drop   <= pend;
      end else begin
        drop <= 1'b0;
        if (cap) begin
          for (int i = 0; i < 3; i++) begin
            if (wr_ptr == 2'(i)) begin
              mem[i] <= i_Fifo_Rd_Data;
            end
          end
          wr_ptr <= ptr_next(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= ptr_next(rd_ptr);
        end
        case ({cap, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  always_comb begin
    o_Data = '0;
    case (rd_ptr)
      2'd0:    o_Data = mem[0];
      2'd1:    o_Data = mem[1];
      2'd2:    o_Data = mem[2];
      default: o_Data = '0;
    endcase
  end

  assign o_Valid = (count != 2'd0);
  assign o_Count = count;

`ifdef FIFO_RD_STREAM_ERR_CHK_EN
  logic err;

  // Unsolicited data (outside a post-flush discard) or a missing return is sticky.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      err <= 1'b0;
    end else if ((i_Fifo_Rd_DV && !pend && !drop) || (pend && !i_Fifo_Rd_DV)) begin
      err <= 1'b1;
    end
  end

  assign o_Err = err;
`else
  assign o_Err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_rd_stream: FIFO model + scoreboard bench for fifo_rd_stream.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fifo_rd_stream;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             fifo_empty = 1'b1;
  logic             rd_en;
  logic             rd_dv = 1'b0;
  logic [WIDTH-1:0] rd_data = '0;
  logic             flush = 1'b0;
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready = 1'b0;
  logic [1:0]       count;
  logic             err;

  always #5 clk = ~clk;

  fifo_rd_stream #(.WIDTH(WIDTH)) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Fifo_Empty   (fifo_empty),
    .o_Fifo_Rd_En   (rd_en),
    .i_Fifo_Rd_DV   (rd_dv),
    .i_Fifo_Rd_Data (rd_data),
    .i_Flush        (flush),
    .o_Valid        (valid),
    .o_Data         (data),
    .i_Ready        (ready),
    .o_Count        (count),
    .o_Err          (err)
  );

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] pop_data[$];
  int               pop_cyc[$];
  int               checks = 0;
  int               passes = 0;
  int               cyc = 0;
  int               reads = 0;
  bit               dv_pending = 1'b0;
  logic [WIDTH-1:0] dv_word = '0;
  bit               drv_rst = 1'b1, drv_ready = 1'b0, drv_flush = 1'b0, drv_inject = 1'b0;
  logic [WIDTH-1:0] inj_word = '0;
  bit               last_rd = 1'b0, last_valid = 1'b0;
  bit               exp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got === expv) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, expv, cyc);
  endtask

  // One clock: apply inputs at the falling edge, then model the FIFO's response.
  task automatic step();
    @(negedge clk);
    cyc++;
    rst     = drv_rst;
    ready   = drv_ready;
    flush   = drv_flush;
    rd_dv   = dv_pending;
    rd_data = dv_pending ? dv_word : '0;
    dv_pending = 1'b0;
    if (drv_inject) begin
      rd_dv   = 1'b1;
      rd_data = inj_word;
`ifdef FIFO_RD_STREAM_ERR_CHK_EN
      exp_err = 1'b1;
`else
      exp_q.push_back(inj_word);
`endif
      drv_inject = 1'b0;
    end
    fifo_empty = (fifo_q.size() == 0);
    #1;
    last_rd    = rd_en;
    last_valid = valid;
    if (rd_en) begin
      if (fifo_q.size() == 0) check("rd_en_when_empty", 1, 0);
      else begin
        dv_word = fifo_q.pop_front();
        dv_pending = 1'b1;
        exp_q.push_back(dv_word);
        reads++;
      end
    end
    if (flush) exp_q.delete();
  endtask

  task automatic do_reset();
    drv_rst = 1'b1; drv_flush = 1'b0; drv_ready = 1'b0;
    step();
    fifo_q.delete(); exp_q.delete(); pop_data.delete(); pop_cyc.delete();
    dv_pending = 1'b0;
    fifo_q.push_back(8'hEE);
    step();
    check("rd_en_in_reset", last_rd, 0);
    step();
    check("reset_valid", valid, 0);
    check("reset_data", data, 0);
    check("reset_count", count, 0);
    check("reset_err", err, 0);
    fifo_q.delete(); exp_q.delete(); dv_pending = 1'b0;
    exp_err = 1'b0; reads = 0;
    drv_rst = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    drv_ready = 1'b1; drv_flush = 1'b0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < max) begin
      step();
      n++;
    end
    step();
    check("drain_done", exp_q.size() + fifo_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every accepted beat and tracks occupancy.
  initial begin : monitor
    logic [WIDTH-1:0] e;
    int occ;
    forever begin
      @(negedge clk); #2;
      if (!rst && valid && ready && !flush) begin
        if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("stream_data", data, e);
          pop_data.push_back(data);
          pop_cyc.push_back(cyc);
        end
      end
      @(posedge clk); #1;
      if (!rst) begin
        occ = exp_q.size() - int'(dv_pending);
        check("count_vs_model", count, occ);
        check("valid_vs_model", valid, occ != 0);
        check("err_state", err, exp_err);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [5:0] rd_pat;
    logic [5:0] v_pat;
    int max_cnt;
    int n;

    // Basic latency: three words, ready held high.
    do_reset();
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
    drv_ready = 1'b1;
    rd_pat = 6'b000111;
    v_pat  = 6'b011100;
    max_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("t1_rd_en", last_rd, rd_pat[k]);
      check("t1_valid", last_valid, v_pat[k]);
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    check("t1_peak_count", max_cnt, 1);
    check("t1_beats", pop_data.size(), 3);

    // Backpressure: five words, ready low, then release.
    do_reset();
    for (int k = 1; k <= 5; k++) fifo_q.push_back(8'(k));
    for (int k = 0; k < 6; k++) step();
    check("t2_reads", reads, 3);
    check("t2_count_full", count, 3);
    check("t2_rd_en_held", last_rd, 0);
    pop_cyc.delete();
    drain(50);
    check("t2_beats", pop_cyc.size(), 5);
    if (pop_cyc.size() == 5) check("t2_no_gaps", pop_cyc[4] - pop_cyc[0], 4);

    // Continuous burst.
    do_reset();
    for (int k = 0; k < 64; k++) fifo_q.push_back(8'(k));
    pop_cyc.delete(); pop_data.delete();
    drain(200);
    check("t3_beats", pop_cyc.size(), 64);
    if (pop_cyc.size() == 64) begin
      check("t3_no_bubbles", pop_cyc[63] - pop_cyc[0], 63);
      check("t3_last_word", pop_data[63], 8'd63);
    end

    // Flush with two buffered words and one in flight.
    do_reset();
    fifo_q.push_back(8'h01); fifo_q.push_back(8'h02);
    fifo_q.push_back(8'h03); fifo_q.push_back(8'hA5);
    for (int k = 0; k < 3; k++) step();
    drv_flush = 1'b1;
    step();
    check("t4_pre_flush_count", count, 2);
    drv_flush = 1'b0; drv_ready = 1'b1;
    pop_data.delete();
    step();
    check("t4_post_flush_count", count, 0);
    check("t4_post_flush_valid", valid, 0);
    drain(50);
    check("t4_beats", pop_data.size(), 1);
    if (pop_data.size() != 0) check("t4_first_after_flush", pop_data[0], 8'hA5);

    // Ready toggling over 20 words.
    do_reset();
    for (int k = 0; k < 20; k++) fifo_q.push_back(8'(8'h40 + k));
    pop_data.delete();
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 200) begin
      drv_ready = cyc[0];
      step();
      n++;
    end
    drain(10);
    check("t5_beats", pop_data.size(), 20);

    // Random traffic with occasional flushes.
    do_reset();
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 1) == 1) fifo_q.push_back(8'($urandom));
      drv_ready = ($urandom_range(0, 3) != 0);
      drv_flush = ($urandom_range(0, 31) == 0);
      step();
    end
    drain(500);

    // Unsolicited read data.
    do_reset();
    step(); step();
    inj_word = 8'h5A;
    drv_inject = 1'b1;
    step();
    step();
    step();
    check("t7_err_held", err, exp_err);
    drain(20);
    do_reset();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
